// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu -- 8-bit combinational arithmetic/logic unit for the 6502-compatible core
//
// Operations (mode): 0 ADD, 1 AND, 2 OR, 3 EOR, 4 SR, 5 SUB, 6..31 reserved.
// Results are available in the same cycle they are requested; there is no
// registered datapath state. While the active-low reset is held low every
// output, including zero, is forced low.
//
// Optional feature macro: ALU_DECIMAL_EN
//   When defined, a `decimal` input is added and ADD/SUB apply NMOS-6502
//   packed-BCD adjustment to alu_out/carry_out when decimal = 1. Overflow
//   stays the binary result; zero/sign follow the adjusted result.
// ----------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       reset,
`ifdef ALU_DECIMAL_EN
  input  logic       decimal,
`endif
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] mode,
  input  logic       carry_in,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero,
  output logic       sign
);

  // Operation encodings; everything from 6 upward is reserved.
  localparam logic [4:0] MODE_ADD = 5'd0;
  localparam logic [4:0] MODE_AND = 5'd1;
  localparam logic [4:0] MODE_OR  = 5'd2;
  localparam logic [4:0] MODE_EOR = 5'd3;
  localparam logic [4:0] MODE_SR  = 5'd4;
  localparam logic [4:0] MODE_SUB = 5'd5;

  // ------------------------------------------------------------------------
  // Arithmetic helpers
  // ------------------------------------------------------------------------

  // 9-bit binary sum used by both ADD and SUB (SUB passes ~b).
  function automatic logic [8:0] add9(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic       cin);
    add9 = {1'b0, a} + {1'b0, b} + {8'h00, cin};
  endfunction

  // Signed overflow for addition: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic [7:0] r);
    add_ovf = (a[7] == b[7]) & (r[7] != a[7]);
  endfunction

  // Signed overflow for subtraction: operands differ in sign and the
  // result sign departs from the minuend.
  function automatic logic sub_ovf(input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic [7:0] r);
    sub_ovf = (a[7] != b[7]) & (r[7] != a[7]);
  endfunction

`ifdef ALU_DECIMAL_EN
  // Packed-BCD addition, NMOS style: each nibble above 9 gets +6 and the
  // corrected low nibble carries into the high nibble. Returns {carry, out}.
  // Six-bit nibble sums leave headroom for invalid (A..F) digit inputs.
  function automatic logic [8:0] bcd_add(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic       cin);
    logic [5:0] lo;
    logic [5:0] hi;
    logic       lo_c;
    lo = {2'b00, a[3:0]} + {2'b00, b[3:0]} + {5'd0, cin};
    if (lo > 6'd9) begin
      lo = lo + 6'd6;
    end else begin
      lo = lo;
    end
    lo_c = (lo > 6'd15);
    hi = {2'b00, a[7:4]} + {2'b00, b[7:4]} + {5'd0, lo_c};
    if (hi > 6'd9) begin
      hi = hi + 6'd6;
    end else begin
      hi = hi;
    end
    bcd_add = {(hi > 6'd15), hi[3:0], lo[3:0]};
  endfunction

  // Packed-BCD subtraction, NMOS style: the binary nibble chain decides the
  // borrows, and each nibble that borrowed is corrected by -6. The returned
  // carry is the binary no-borrow. Returns {carry, out}.
  function automatic logic [8:0] bcd_sub(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic       cin);
    logic [4:0] lo;
    logic [4:0] hi;
    logic [3:0] lo_adj;
    logic [3:0] hi_adj;
    lo = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'd0, cin};
    if (lo[4]) begin
      lo_adj = lo[3:0];
    end else begin
      lo_adj = lo[3:0] - 4'd6;
    end
    hi = {1'b0, a[7:4]} + {1'b0, ~b[7:4]} + {4'd0, lo[4]};
    if (hi[4]) begin
      hi_adj = hi[3:0];
    end else begin
      hi_adj = hi[3:0] - 4'd6;
    end
    bcd_sub = {hi[4], hi_adj, lo_adj};
  endfunction
`endif

  // ------------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------------

  logic [8:0] sum_s;       // scratch binary sum for ADD/SUB
  logic [7:0] bin_res_s;   // binary result before any decimal correction
  logic       bin_carry_s;
  logic       bin_ovf_s;
  logic [7:0] res_s;       // final result (after decimal correction if any)
  logic       res_carry_s;

  // The datapath is purely combinational; the clock only exists so the
  // block sits in the core's clock domain alongside its neighbours.
  logic       clk_unused_s;
  assign clk_unused_s = clk;

  // Binary operation select; reserved modes fall through to all-zero.
  always_comb begin
    sum_s       = 9'h000;
    bin_res_s   = 8'h00;
    bin_carry_s = 1'b0;
    bin_ovf_s   = 1'b0;
    case (mode)
      MODE_ADD: begin
        sum_s       = add9(alu_a, alu_b, carry_in);
        bin_res_s   = sum_s[7:0];
        bin_carry_s = sum_s[8];
        bin_ovf_s   = add_ovf(alu_a, alu_b, sum_s[7:0]);
      end
      MODE_SUB: begin
        sum_s       = add9(alu_a, ~alu_b, carry_in);
        bin_res_s   = sum_s[7:0];
        bin_carry_s = sum_s[8];
        bin_ovf_s   = sub_ovf(alu_a, alu_b, sum_s[7:0]);
      end
      MODE_AND: begin
        bin_res_s   = alu_a & alu_b;
        bin_carry_s = 1'b0;
        bin_ovf_s   = 1'b0;
      end
      MODE_OR: begin
        bin_res_s   = alu_a | alu_b;
        bin_carry_s = 1'b0;
        bin_ovf_s   = 1'b0;
      end
      MODE_EOR: begin
        bin_res_s   = alu_a ^ alu_b;
        bin_carry_s = 1'b0;
        bin_ovf_s   = 1'b0;
      end
      MODE_SR: begin
        // Logical shift right: bit 0 drops into carry, bit 7 fills with 0.
        bin_res_s   = {1'b0, alu_a[7:1]};
        bin_carry_s = alu_a[0];
        bin_ovf_s   = 1'b0;
      end
      default: begin
        sum_s       = 9'h000;
        bin_res_s   = 8'h00;
        bin_carry_s = 1'b0;
        bin_ovf_s   = 1'b0;
      end
    endcase
  end

`ifdef ALU_DECIMAL_EN
  // Decimal correction of ADD/SUB; every other case passes the binary result.
  always_comb begin
    res_s       = bin_res_s;
    res_carry_s = bin_carry_s;
    if (decimal && (mode == MODE_ADD)) begin
      {res_carry_s, res_s} = bcd_add(alu_a, alu_b, carry_in);
    end else if (decimal && (mode == MODE_SUB)) begin
      {res_carry_s, res_s} = bcd_sub(alu_a, alu_b, carry_in);
    end else begin
      res_s       = bin_res_s;
      res_carry_s = bin_carry_s;
    end
  end
`else
  // Binary-only build: the final result is the binary result.
  always_comb begin
    res_s       = bin_res_s;
    res_carry_s = bin_carry_s;
  end
`endif

  // Output stage: reset low clamps every flag (including zero) to 0 without
  // waiting for a clock; otherwise flags are derived from the final result.
  always_comb begin
    alu_out   = 8'h00;
    carry_out = 1'b0;
    overflow  = 1'b0;
    zero      = 1'b0;
    sign      = 1'b0;
    if (reset) begin
      alu_out   = res_s;
      carry_out = res_carry_s;
      overflow  = bin_ovf_s;
      zero      = (res_s == 8'h00);
      sign      = res_s[7];
    end else begin
      alu_out   = 8'h00;
      carry_out = 1'b0;
      overflow  = 1'b0;
      zero      = 1'b0;
      sign      = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu -- directed self-checking bench for alu.
// Outputs are compared as a packed 12-bit word {alu_out, C, V, Z, N}.
// ----------------------------------------------------------------------------
module tb_alu;

  logic       clk;
  logic       reset;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] mode;
  logic       carry_in;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       overflow;
  logic       zero;
  logic       sign;
`ifdef ALU_DECIMAL_EN
  logic       decimal;
`endif

  int checks   = 0;
  int failures = 0;

  alu dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ALU_DECIMAL_EN
    .decimal   (decimal),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .mode      (mode),
    .carry_in  (carry_in),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the packed output word against a hand-computed expectation.
  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    got = {alu_out, carry_out, overflow, zero, sign};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got out=%h C=%b V=%b Z=%b N=%b, expected out=%h C=%b V=%b Z=%b N=%b",
             tag, got[11:4], got[3], got[2], got[1], got[0],
             exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive a vector just after a falling edge and let it settle.
  task automatic apply(input logic [4:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    @(negedge clk);
    mode     = m;
    alu_a    = a;
    alu_b    = b;
    carry_in = c;
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    mode     = 5'd0;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    carry_in = 1'b0;
`ifdef ALU_DECIMAL_EN
    decimal  = 1'b0;
`endif

    // Reset held: ADD FF+01 would give 00/C/Z, but everything is forced 0.
    apply(5'd0, 8'hFF, 8'h01, 1'b0);
    check("reset_hold", {8'h00, 1'b0, 1'b0, 1'b0, 1'b0});

    // Release without a clock edge: result appears immediately.
    reset = 1'b1;
    #1;
    check("reset_release", {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});

    apply(5'd0, 8'h50, 8'h50, 1'b0);
    check("add_50_50", {8'hA0, 1'b0, 1'b1, 1'b0, 1'b1});

    apply(5'd0, 8'h10, 8'h20, 1'b1);
    check("add_cin", {8'h31, 1'b0, 1'b0, 1'b0, 1'b0});

    apply(5'd0, 8'hFF, 8'h01, 1'b1);
    check("add_wrap_cin", {8'h01, 1'b1, 1'b0, 1'b0, 1'b0});

    apply(5'd0, 8'h80, 8'h80, 1'b0);
    check("add_neg_ovf", {8'h00, 1'b1, 1'b1, 1'b1, 1'b0});

    apply(5'd5, 8'h50, 8'hB0, 1'b1);
    check("sub_50_B0", {8'hA0, 1'b0, 1'b1, 1'b0, 1'b1});

    apply(5'd5, 8'h05, 8'h05, 1'b1);
    check("sub_equal", {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});

    apply(5'd5, 8'h05, 8'h05, 1'b0);
    check("sub_equal_borrow", {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});

    apply(5'd5, 8'h00, 8'h01, 1'b1);
    check("sub_underflow", {8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});

    apply(5'd1, 8'hF0, 8'h3C, 1'b1);
    check("and_cin_ignored", {8'h30, 1'b0, 1'b0, 1'b0, 1'b0});

    apply(5'd2, 8'h81, 8'h02, 1'b1);
    check("or", {8'h83, 1'b0, 1'b0, 1'b0, 1'b1});

    apply(5'd3, 8'hFF, 8'hFF, 1'b1);
    check("eor_zero", {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    apply(5'd4, 8'h81, 8'hFF, 1'b1);
    check("sr_81", {8'h40, 1'b1, 1'b0, 1'b0, 1'b0});

    apply(5'd4, 8'h01, 8'h00, 1'b0);
    check("sr_to_zero", {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});

    apply(5'd6, 8'hFF, 8'hFF, 1'b1);
    check("reserved_6", {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    apply(5'd7, 8'h80, 8'h80, 1'b1);
    check("reserved_7", {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    apply(5'd31, 8'hFF, 8'h01, 1'b0);
    check("reserved_31", {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    // Mode change alone must re-evaluate everything.
    apply(5'd0, 8'h50, 8'h50, 1'b0);
    check("mode_change_add", {8'hA0, 1'b0, 1'b1, 1'b0, 1'b1});
    mode = 5'd1;
    #1;
    check("mode_change_and", {8'h50, 1'b0, 1'b0, 1'b0, 1'b0});

    // Asynchronous assertion of reset mid-cycle.
    apply(5'd5, 8'h50, 8'hB0, 1'b1);
    reset = 1'b0;
    #1;
    check("reset_async", {8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    reset = 1'b1;
    #1;
    check("reset_async_release", {8'hA0, 1'b0, 1'b1, 1'b0, 1'b1});

`ifdef ALU_DECIMAL_EN
    decimal = 1'b1;
    apply(5'd0, 8'h19, 8'h01, 1'b0);
    check("bcd_add_19_01", {8'h20, 1'b0, 1'b0, 1'b0, 1'b0});

    apply(5'd0, 8'h99, 8'h01, 1'b0);
    check("bcd_add_99_01", {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});

    apply(5'd5, 8'h10, 8'h01, 1'b1);
    check("bcd_sub_10_01", {8'h09, 1'b1, 1'b0, 1'b0, 1'b0});

    apply(5'd1, 8'h19, 8'h0F, 1'b0);
    check("bcd_logic_unaffected", {8'h09, 1'b0, 1'b0, 1'b0, 1'b0});
    decimal = 1'b0;

    apply(5'd0, 8'h19, 8'h01, 1'b0);
    check("bcd_off_binary", {8'h1A, 1'b0, 1'b0, 1'b0, 1'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
